// File: rtl/pipe_stage_skid_pkg.sv
// Shared definitions for the inter-stage pipeline registers: standard payload
// layouts, their widths, occupancy codes and the skid-stage state encoding.
package pipe_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned REG_IDX_W  = 5;
    localparam int unsigned ALU_CTRL_W = 4;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } if_id_t;

    typedef struct packed {
        logic [XLEN-1:0]       rs1_val;
        logic [XLEN-1:0]       rs2_val;
        logic [REG_IDX_W-1:0]  rd;
        logic [ALU_CTRL_W-1:0] alu_ctrl;
        logic                  alu_src;
        logic [XLEN-1:0]       imm;
    } id_ex_t;

    typedef struct packed {
        logic [XLEN-1:0]      alu_result;
        logic [XLEN-1:0]      store_data;
        logic [REG_IDX_W-1:0] rd;
        logic                 mem_read;
        logic                 mem_write;
        logic                 reg_write;
        logic                 mem_to_reg;
    } ex_mem_t;

    typedef struct packed {
        logic [XLEN-1:0]      wb_data;
        logic [REG_IDX_W-1:0] rd;
        logic                 reg_write;
    } mem_wb_t;

    localparam int unsigned IF_ID_W   = $bits(if_id_t);
    localparam int unsigned ID_EX_W   = $bits(id_ex_t);
    localparam int unsigned EX_MEM_W  = $bits(ex_mem_t);
    localparam int unsigned MEM_WB_W  = $bits(mem_wb_t);
    localparam int unsigned DEFAULT_W = 108;

    localparam logic [1:0] OCC_EMPTY = 2'd0;
    localparam logic [1:0] OCC_ONE   = 2'd1;
    localparam logic [1:0] OCC_FULL  = 2'd2;

    // Encoded as {skid_valid, main_valid}; 2'b10 cannot occur.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_FULL  = 2'b11
    } skid_state_t;

    function automatic logic [1:0] occ_of(input skid_state_t s);
        case (s)
            ST_ONE:  return OCC_ONE;
            ST_FULL: return OCC_FULL;
            default: return OCC_EMPTY;
        endcase
    endfunction

endpackage

// File: rtl/pipe_stage_skid_entry_reg.sv
// One pipeline storage slot: a valid bit plus payload. Flush beats load,
// load beats drop; drop only invalidates and leaves the payload in place.
module pipe_entry_reg
    import pipe_pkg::*;
#(
    parameter int unsigned W             = DEFAULT_W,
    parameter bit          ZERO_ON_FLUSH = 1'b1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic         load,
    input  logic         drop,
    input  logic [W-1:0] d,
    output logic         valid,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid <= 1'b0;
            q     <= '0;
        end else if (flush) begin
            valid <= 1'b0;
            if (ZERO_ON_FLUSH) begin
                q <= '0;
            end
        end else if (load) begin
            valid <= 1'b1;
            q     <= d;
        end else if (drop) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/pipe_stage.sv
// Generic valid/ready pipeline register with optional two-entry skid buffer
// and synchronous flush; the payload is opaque and passed bit-exact.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int unsigned PAYLOAD_W     = DEFAULT_W,
    parameter bit          SKID          = 1'b1,
    parameter bit          ZERO_ON_FLUSH = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [PAYLOAD_W-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [PAYLOAD_W-1:0] out_data,
    output logic [1:0]           occupancy
);

    logic                 main_v;
    logic [PAYLOAD_W-1:0] main_q;
    logic [PAYLOAD_W-1:0] main_d;
    logic                 main_load;
    logic                 main_drop;
    logic                 skid_v;
    logic [PAYLOAD_W-1:0] skid_q;
    logic                 skid_load;
    logic                 skid_drop;
    logic                 in_fire;
    logic                 out_fire;
    skid_state_t          state;

    pipe_entry_reg #(
        .W             (PAYLOAD_W),
        .ZERO_ON_FLUSH (ZERO_ON_FLUSH)
    ) u_main (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .load  (main_load),
        .drop  (main_drop),
        .d     (main_d),
        .valid (main_v),
        .q     (main_q)
    );

    generate
        if (SKID) begin : g_skid
            pipe_entry_reg #(
                .W             (PAYLOAD_W),
                .ZERO_ON_FLUSH (ZERO_ON_FLUSH)
            ) u_skid (
                .clk   (clk),
                .reset (reset),
                .flush (flush),
                .load  (skid_load),
                .drop  (skid_drop),
                .d     (in_data),
                .valid (skid_v),
                .q     (skid_q)
            );
            // Registered ready: only the skid slot being full can block input.
            assign in_ready = ~skid_v;
        end else begin : g_single
            assign skid_v   = 1'b0;
            assign skid_q   = '0;
            assign in_ready = ~main_v | out_ready;
        end
    endgenerate

    assign state     = skid_state_t'({skid_v, main_v});
    assign out_valid = main_v;
    assign out_data  = main_q;
    assign occupancy = occ_of(state);
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = main_v & out_ready;

    always_comb begin
        main_load = 1'b0;
        main_drop = 1'b0;
        skid_load = 1'b0;
        skid_drop = 1'b0;
        main_d    = in_data;
        if (SKID) begin
            case (state)
                ST_EMPTY: begin
                    main_load = in_fire;
                end
                ST_ONE: begin
                    if (out_fire && in_fire) begin
                        main_load = 1'b1;
                    end else if (out_fire) begin
                        main_drop = 1'b1;
                    end else if (in_fire) begin
                        skid_load = 1'b1;
                    end
                end
                ST_FULL: begin
                    if (out_fire) begin
                        main_load = 1'b1;
                        main_d    = skid_q;
                        skid_drop = 1'b1;
                    end
                end
                default: ;
            endcase
        end else begin
            if (in_fire) begin
                main_load = 1'b1;
            end else if (out_fire) begin
                main_drop = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed plus randomised bench for pipe_stage_skid (SKID=1 and SKID=0 instances)
// checked against a queue-based reference model.
module tb_pipe_stage_skid;

    localparam int PW = 108;

    logic clk = 1'b0;
    logic reset;
    logic flush;

    logic          a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [PW-1:0] a_in_data, a_out_data;
    logic [1:0]    a_occupancy;
    logic          b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [PW-1:0] b_in_data, b_out_data;
    logic [1:0]    b_occupancy;

    logic [PW-1:0] qa[$];
    logic [PW-1:0] qb[$];
    int unsigned   a_del = 0;
    int unsigned   b_del = 0;
    int unsigned   n_checks = 0;
    int unsigned   n_err = 0;

    always #5 clk = ~clk;

    pipe_stage_skid #(.PAYLOAD_W(PW), .SKID(1'b1), .ZERO_ON_FLUSH(1'b1)) dut_a (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .occupancy(a_occupancy)
    );

    pipe_stage_skid #(.PAYLOAD_W(PW), .SKID(1'b0), .ZERO_ON_FLUSH(1'b1)) dut_b (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .occupancy(b_occupancy)
    );

    task automatic chk(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [PW-1:0] rnd_payload();
        logic [127:0] t;
        t = {$urandom, $urandom, $urandom, $urandom};
        return t[PW-1:0];
    endfunction

    task automatic check_all();
        chk("a_in_ready", PW'(a_in_ready), PW'(qa.size() < 2));
        chk("a_out_valid", PW'(a_out_valid), PW'(qa.size() > 0));
        chk("a_occupancy", PW'(a_occupancy), PW'(qa.size()));
        if (qa.size() > 0) chk("a_out_data", a_out_data, qa[0]);
        chk("b_in_ready", PW'(b_in_ready), PW'(qb.size() == 0 || b_out_ready));
        chk("b_out_valid", PW'(b_out_valid), PW'(qb.size() > 0));
        chk("b_occupancy", PW'(b_occupancy), PW'(qb.size()));
        if (qb.size() > 0) chk("b_out_data", b_out_data, qb[0]);
    endtask

    task automatic model_update();
        bit a_in_f, a_out_f, b_in_f, b_out_f;
        a_in_f  = a_in_valid && (qa.size() < 2);
        a_out_f = (qa.size() > 0) && a_out_ready;
        b_in_f  = b_in_valid && (qb.size() == 0 || b_out_ready);
        b_out_f = (qb.size() > 0) && b_out_ready;
        if (a_out_f) a_del++;
        if (b_out_f) b_del++;
        if (flush) begin
            qa.delete();
            qb.delete();
        end else begin
            if (a_out_f) void'(qa.pop_front());
            if (a_in_f) qa.push_back(a_in_data);
            if (b_out_f) void'(qb.pop_front());
            if (b_in_f) qb.push_back(b_in_data);
        end
    endtask

    task automatic check_phase();
        @(negedge clk);
        check_all();
    endtask

    task automatic edge_phase();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic cycle();
        check_phase();
        edge_phase();
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0;
        a_in_valid = 1'b0; a_out_ready = 1'b0; a_in_data = '0;
        b_in_valid = 1'b0; b_out_ready = 1'b0; b_in_data = '0;
        #1;
        chk("rst_a_out_valid", PW'(a_out_valid), PW'(1'b0));
        chk("rst_a_out_data", a_out_data, '0);
        chk("rst_a_occupancy", PW'(a_occupancy), PW'(2'd0));
        chk("rst_a_in_ready", PW'(a_in_ready), PW'(1'b1));
        chk("rst_b_in_ready", PW'(b_in_ready), PW'(1'b1));
        chk("rst_b_out_valid", PW'(b_out_valid), PW'(1'b0));
        @(posedge clk); #2;
        reset = 1'b0;
        #1;

        // Streaming with downstream always ready
        a_out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            a_in_valid = 1'b1;
            a_in_data  = PW'(i);
            cycle();
        end
        a_in_valid = 1'b0;
        cycle();

        // Backpressure into the skid slot, stall, then drain
        a_out_ready = 1'b0;
        a_in_valid = 1'b1; a_in_data = PW'(12'h0A);
        cycle();
        a_in_data = PW'(12'h0B);
        cycle();
        a_in_valid = 1'b1; a_in_data = PW'(12'h0D);
        for (int i = 0; i < 3; i++) cycle();
        a_in_valid = 1'b0;
        a_out_ready = 1'b1;
        for (int i = 0; i < 3; i++) cycle();

        // Flush while full; the concurrent incoming beat must vanish
        a_out_ready = 1'b0;
        a_in_valid = 1'b1; a_in_data = PW'(12'h0A);
        b_in_valid = 1'b1; b_in_data = PW'(12'h77);
        cycle();
        b_in_valid = 1'b0;
        a_in_data = PW'(12'h0B);
        cycle();
        flush = 1'b1;
        a_in_data = PW'(12'h0C);
        cycle();
        flush = 1'b0;
        a_in_valid = 1'b0;
        check_phase();
        chk("flush_a_out_data", a_out_data, '0);
        chk("flush_b_out_data", b_out_data, '0);
        edge_phase();
        a_out_ready = 1'b1; b_out_ready = 1'b1;
        for (int i = 0; i < 3; i++) cycle();

        // Asynchronous reset between clock edges with two beats held
        a_out_ready = 1'b0;
        a_in_valid = 1'b1; a_in_data = PW'(12'h11);
        cycle();
        a_in_data = PW'(12'h22);
        cycle();
        a_in_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk("arst_a_out_valid", PW'(a_out_valid), PW'(1'b0));
        chk("arst_a_occupancy", PW'(a_occupancy), PW'(2'd0));
        chk("arst_a_out_data", a_out_data, '0);
        chk("arst_a_in_ready", PW'(a_in_ready), PW'(1'b1));
        reset = 1'b0;
        qa.delete();
        qb.delete();
        a_out_ready = 1'b1;
        for (int i = 0; i < 3; i++) cycle();

        // SKID=0: ready follows out_ready combinationally within the cycle
        b_out_ready = 1'b0;
        b_in_valid = 1'b1; b_in_data = PW'(12'h3);
        cycle();
        b_in_data = PW'(12'h5);
        check_phase();
        b_out_ready = 1'b1;
        #1;
        chk("b_ready_comb", PW'(b_in_ready), PW'(1'b1));
        edge_phase();
        b_in_valid = 1'b0;
        check_phase();
        chk("b_accept_5", b_out_data, PW'(12'h5));
        edge_phase();
        cycle();

        // Randomised traffic on both instances against the queue model
        begin
            int unsigned cyc = 0;
            a_del = 0; b_del = 0;
            while ((a_del < 1000 || b_del < 1000) && cyc < 20000) begin
                a_in_valid  = ($urandom_range(0, 9) < 7);
                a_out_ready = ($urandom_range(0, 9) < 6);
                a_in_data   = rnd_payload();
                b_in_valid  = ($urandom_range(0, 9) < 7);
                b_out_ready = ($urandom_range(0, 9) < 6);
                b_in_data   = rnd_payload();
                flush       = ($urandom_range(0, 199) == 0);
                cycle();
                cyc++;
            end
            flush = 1'b0;
            chk("rand_progress", PW'(a_del >= 1000 && b_del >= 1000), PW'(1'b1));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Generic, parametrised inter-stage pipeline register for the 5-stage core. It replaces the fixed-field per-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries an opaque payload of PAYLOAD_W bits. Each parent packs its own fields (operands, Rd, ALU control, ALU source, immediate).
- Adds a valid/ready handshake, an optional 2-entry skid buffer that breaks the combinational ready path, and a synchronous flush for branch/exception squash.

Parameters:
- PAYLOAD_W, 108, payload width in bits (default fits 2x32 data + 5 Rd + 4 ctrl + 1 src + 32 imm, rounded up).
- SKID, 1, 1 = two entries with registered in_ready; 0 = single entry with in_ready = ~out_valid | out_ready.
- ZERO_ON_FLUSH, 1, 1 = clear payload storage on flush; 0 = only clear valid bits (saves area).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- flush  input  1  synchronous squash of all held and incoming beats
- in_valid  input  1  upstream beat present
- in_ready  output  1  stage can accept a beat this cycle
- in_data  input  PAYLOAD_W  upstream payload
- out_valid  output  1  downstream beat present
- out_ready  input  1  downstream accepts this cycle
- out_data  output  PAYLOAD_W  downstream payload
- occupancy  output  2  number of valid entries held (0..2; max 1 when SKID=0)

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-high. While reset is high:
  - out_valid=0, out_data=0, occupancy=0.
  - skid entry invalid and zeroed.
  - in_ready=1 when SKID=1; in_ready=1 when SKID=0, since out_valid=0.
- Handshakes: a beat transfers on the input when in_valid & in_ready at a rising edge. It transfers on the output when out_valid & out_ready.
- Latency: one cycle, in_data to out_data, when the stage is empty or draining.
- Payload stability: out_data and out_valid must not change while out_valid & ~out_ready, except on flush or reset.
- SKID=1 state machine, with state encoded by main/skid valid bits:
  - EMPTY (occ 0), in_ready=1.
    - in fire -> ONE; payload into main.
  - ONE (occ 1), in_ready=1.
    - out fire & in fire -> ONE; main <= in_data.
    - out fire only -> EMPTY.
    - in fire only -> FULL; in_data into skid.
    - neither -> hold.
  - FULL (occ 2), in_ready=0 (registered, depends only on state).
    - out fire -> ONE; main <= skid, skid invalidated.
    - otherwise hold.
- SKID=0: single entry.
  - in_ready = ~out_valid | out_ready (combinational).
  - Accept loads main. Out fire with no accept clears valid.
- Flush:
  - At the edge where flush=1, all entries become invalid; occupancy=0 next cycle.
  - The incoming beat that cycle is dropped even if in_valid & in_ready.
  - If ZERO_ON_FLUSH=1, main and skid payloads are cleared.
  - in_ready is 1 the cycle after flush.
- Flush priority: flush has priority over all handshakes. An out fire coinciding with flush still counts as delivered downstream; the stage simply holds nothing afterwards.
- Reset mid-operation: all state is lost immediately and asynchronously. No beat is delivered after reset deasserts until a new in fire.
- Width: payload is passed bit-exact; no arithmetic. occupancy never exceeds 2.
- Ordering: beats leave in arrival order, with no loss or duplication absent flush.

Decomposition:
- Shared package pipe_pkg:
  - localparam widths for the standard payloads (ID_EX_W, EX_MEM_W, MEM_WB_W).
  - packed struct typedefs per stage so parents pack/unpack by field name.
  - occupancy encodings OCC_EMPTY, OCC_ONE, OCC_FULL.
- Natural sub-module: pipe_entry_reg. It holds one valid bit plus payload with async reset, load enable and clear enable. It is instantiated once for main and once (under SKID) for skid.

Test Plan:
- Reset then stream: in_valid=1 with data 1,2,3,... and out_ready=1 every cycle -> out_data 1,2,3 appearing one cycle later, in_ready constantly 1, occupancy 1.
- Backpressure (SKID=1): send 0xA then 0xB while out_ready=0 -> occupancy 2, in_ready=0. Raise out_ready -> 0xA then 0xB delivered on consecutive cycles, out_data held stable while stalled.
- Flush at FULL: hold 0xA, 0xB, assert flush with in_valid=1, data 0xC -> next cycle out_valid=0, occupancy=0, 0xC never emitted, out_data=0 (ZERO_ON_FLUSH=1).
- Async reset mid-stream: assert reset between clock edges with occupancy 2 -> out_valid and occupancy drop to 0 without a clock edge. After release, no stale beat is emitted.
- SKID=0 combinational ready: out_valid=1, out_ready=0 -> in_ready=0. Toggle out_ready=1 in the same cycle -> in_ready=1 and new beat 0x5 accepted that edge.
- Randomised valid/ready with scoreboard: 1000 beats -> output sequence equals input sequence, occupancy ≤ 2, no out_data change while stalled.
